// File: rtl/lcd_pixel_fetch_if.sv
// Burst read port between the pixel prefetch stage (master) and the
// frame-buffer memory controller (slave).
interface lcd_pixel_fetch_if #(
   parameter int ADDR_W = 24
);
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic [7:0]        rd_len;
   logic              rd_ack;
   logic              rd_valid;
   logic [15:0]       rd_data;

   modport master (
      output rd_req, rd_addr, rd_len,
      input  rd_ack, rd_valid, rd_data
   );

   modport slave (
      input  rd_req, rd_addr, rd_len,
      output rd_ack, rd_valid, rd_data
   );
endinterface

// File: rtl/lcd_pixel_fetch.sv
// Show-ahead pixel FIFO refilled by burst reads, restarted on each frame sync.
// Define LCD_PIXEL_FETCH_STATS_EN to add the per-frame underflow_cnt output.
module lcd_pixel_fetch #(
   parameter int                DEPTH           = 512,
   parameter int                BURST_LEN       = 64,
   parameter int                ADDR_W          = 24,
   parameter logic [ADDR_W-1:0] FRAME_BASE      = 24'h000000,
   parameter int                FRAME_WORDS     = 384000,
   parameter logic [15:0]       UNDERFLOW_COLOR = 16'h0000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   lcd_request,
   input  logic                   lcd_framesync,
   output logic [15:0]            lcd_data,
   lcd_pixel_fetch_if.master      bus,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   underflow
`ifdef LCD_PIXEL_FETCH_STATS_EN
   ,
   output logic [15:0]            underflow_cnt
`endif
);

   localparam int PW    = $clog2(DEPTH);
   localparam int CW    = PW + 1;
   localparam int REM_W = $clog2(FRAME_WORDS + 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA} state_t;

   state_t             state, state_nxt;
   logic               fs_prev;
   logic               flush_pend;
   logic [REM_W-1:0]   remaining;
   logic [ADDR_W-1:0]  rd_addr_q;
   logic [7:0]         rd_len_q;
   logic [7:0]         beat_cnt;
   logic [PW-1:0]      wr_ptr, rd_ptr;
   logic [15:0]        ram [DEPTH];

   logic empty, pop, push, frame_fall, flush, last_beat, start, empty_req;

   function automatic logic [7:0] burst_len_of(input logic [REM_W-1:0] rem);
      if (32'(rem) < BURST_LEN) return 8'(rem);
      else return 8'(BURST_LEN);
   endfunction

   always_comb begin
      empty      = (fifo_count == '0);
      pop        = lcd_request && !empty;
      empty_req  = lcd_request && empty;
      push       = (state == S_DATA) && bus.rd_valid;
      frame_fall = fs_prev && !lcd_framesync;
      flush      = (state == S_IDLE) && flush_pend;
      last_beat  = push && (beat_cnt == 8'd1);
      lcd_data   = empty ? UNDERFLOW_COLOR : ram[rd_ptr];
   end

   assign bus.rd_req  = (state == S_REQ);
   assign bus.rd_addr = rd_addr_q;
   assign bus.rd_len  = rd_len_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // A pending frame start holds the FSM in IDLE so bursts never straddle a flush.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: if (!flush_pend && (remaining != '0) &&
                     (fifo_count <= CW'(DEPTH - BURST_LEN)))
                    state_nxt = S_REQ;
         S_REQ:  if (bus.rd_ack) state_nxt = S_DATA;
         S_DATA: if (last_beat) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      start = (state == S_IDLE) && (state_nxt == S_REQ);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fs_prev    <= 1'b0;
         flush_pend <= 1'b0;
         remaining  <= REM_W'(FRAME_WORDS);
         rd_addr_q  <= FRAME_BASE;
         rd_len_q   <= 8'd0;
         beat_cnt   <= 8'd0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         underflow  <= 1'b0;
      end else begin
         fs_prev <= lcd_framesync;
         // A new edge arriving on the flush cycle re-arms rather than being lost.
         if (frame_fall) flush_pend <= 1'b1;
         else if (flush) flush_pend <= 1'b0;

         if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            rd_addr_q  <= FRAME_BASE;
            remaining  <= REM_W'(FRAME_WORDS);
            underflow  <= 1'b0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      fifo_count <= fifo_count + CW'(1);
            else if (pop && !push) fifo_count <= fifo_count - CW'(1);
            if (empty_req) underflow <= 1'b1;
            if (start) begin
               rd_len_q <= burst_len_of(remaining);
               beat_cnt <= burst_len_of(remaining);
            end else if (push) begin
               beat_cnt <= beat_cnt - 8'd1;
            end
            if (last_beat) begin
               rd_addr_q <= rd_addr_q + ADDR_W'(rd_len_q);
               remaining <= remaining - REM_W'(rd_len_q);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) ram[wr_ptr] <= bus.rd_data;
   end

`ifdef LCD_PIXEL_FETCH_STATS_EN
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         underflow_cnt <= 16'd0;
      else if (flush)     underflow_cnt <= 16'd0;
      else if (empty_req) underflow_cnt <= sat_inc16(underflow_cnt);
   end
`else
   // Without the statistics option the sticky underflow flag is the only report.
`endif

endmodule

// File: tb/tb_lcd_pixel_fetch.sv
// Directed bench for lcd_pixel_fetch with an in-line burst memory responder.
module tb_lcd_pixel_fetch;
   localparam int          LAT = 10;
   localparam logic [15:0] UFC = 16'hF81F;

   logic        clk = 1'b0;
   logic        rst_n, lcd_request, lcd_framesync;
   logic [15:0] lcd_data;
   logic [9:0]  fifo_count;
   logic        underflow;
`ifdef LCD_PIXEL_FETCH_STATS_EN
   logic [15:0] underflow_cnt;
`endif

   lcd_pixel_fetch_if #(.ADDR_W(24)) bus ();

   lcd_pixel_fetch #(
      .DEPTH(512), .BURST_LEN(64), .ADDR_W(24), .FRAME_BASE(24'h000000),
      .FRAME_WORDS(548), .UNDERFLOW_COLOR(UFC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .lcd_request(lcd_request),
      .lcd_framesync(lcd_framesync), .lcd_data(lcd_data), .bus(bus),
      .fifo_count(fifo_count), .underflow(underflow)
`ifdef LCD_PIXEL_FETCH_STATS_EN
      , .underflow_cnt(underflow_cnt)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int log_addr[$];
   int log_len[$];
   int m_st = 0, m_wait = 0, m_addr = 0, m_left = 0, m_tick = 0, peak = 0;
   bit auto_mem = 1'b0;
   int base;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int la(input int i);
      return (log_addr.size() > i) ? log_addr[i] : -1;
   endfunction

   function automatic int ll(input int i);
      return (log_len.size() > i) ? log_len[i] : -1;
   endfunction

   // One clock, then the memory responder decides what to drive for the next edge.
   task automatic tick();
      @(posedge clk);
      #1;
      m_tick++;
      bus.rd_ack   = 1'b0;
      bus.rd_valid = 1'b0;
      if (auto_mem) begin
         case (m_st)
            0: if (bus.rd_req) begin
                  log_addr.push_back(int'(bus.rd_addr));
                  log_len.push_back(int'(bus.rd_len));
                  m_addr = int'(bus.rd_addr);
                  m_left = int'(bus.rd_len);
                  m_wait = LAT;
                  m_st   = 1;
               end
            1: if (m_wait == 0) begin
                  bus.rd_ack = 1'b1;
                  m_st = 2;
               end else begin
                  m_wait--;
               end
            2: if (m_tick % 7 != 6) begin
                  bus.rd_valid = 1'b1;
                  bus.rd_data  = 16'(m_addr);
                  m_addr++;
                  m_left--;
                  if (m_left == 0) m_st = 0;
               end
            default: m_st = 0;
         endcase
      end
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
   endtask

   initial begin
      rst_n = 1'b0; lcd_request = 1'b0; lcd_framesync = 1'b1;
      bus.rd_ack = 1'b0; bus.rd_valid = 1'b0; bus.rd_data = 16'h0;
      repeat (3) tick();
      chk("rst_rd_req", 32'(bus.rd_req), 0);
      chk("rst_rd_addr", 32'(bus.rd_addr), 0);
      chk("rst_rd_len", 32'(bus.rd_len), 0);
      chk("rst_count", 32'(fifo_count), 0);
      chk("rst_underflow", 32'(underflow), 0);
      chk("rst_lcd_data", 32'(lcd_data), 32'(UFC));

      // First burst is requested right after reset; frame start arrives during REQ.
      rst_n = 1'b1;
      tick();
      chk("req_first", 32'(bus.rd_req), 1);
      chk("req_first_addr", 32'(bus.rd_addr), 0);
      chk("req_first_len", 32'(bus.rd_len), 64);
      lcd_framesync = 1'b0;
      repeat (5) tick();
      chk("req_held", 32'(bus.rd_req), 1);
      lcd_framesync = 1'b1;
      auto_mem = 1'b1;

      for (int i = 0; i < 500 && log_addr.size() < 2; i++) tick();
      chk("second_burst_seen", 32'(log_addr.size() >= 2), 1);
      chk("flush_restart_addr", 32'(la(1)), 0);

      // Fill: 8 bursts of 64 after the restart, then no more space.
      repeat (1500) tick();
      chk("fill_bursts", 32'(log_addr.size()), 9);
      chk("fill_last_addr", 32'(la(8)), 448);
      chk("fill_last_len", 32'(ll(8)), 64);
      chk("fill_count", 32'(fifo_count), 512);
      chk("fill_no_req", 32'(bus.rd_req), 0);
      chk("fill_head", 32'(lcd_data), 0);

      // Stream the whole 548-word frame; the 36-word tail burst arrives meanwhile.
      lcd_request = 1'b1;
      for (int i = 0; i < 548; i++) begin
         chk("stream_word", 32'(lcd_data), 32'(i));
         tick();
      end
      lcd_request = 1'b0;
      chk("stream_count", 32'(fifo_count), 0);
      chk("stream_underflow", 32'(underflow), 0);
      chk("tail_bursts", 32'(log_addr.size()), 10);
      chk("tail_addr", 32'(la(9)), 512);
      chk("tail_len", 32'(ll(9)), 36);
      repeat (100) tick();
      chk("frame_done_bursts", 32'(log_addr.size()), 10);
      chk("frame_done_no_req", 32'(bus.rd_req), 0);

      // Three requests against an empty FIFO.
      chk("empty_color", 32'(lcd_data), 32'(UFC));
      lcd_request = 1'b1;
      repeat (3) tick();
      lcd_request = 1'b0;
      chk("uf_set", 32'(underflow), 1);
      chk("uf_color", 32'(lcd_data), 32'(UFC));
`ifdef LCD_PIXEL_FETCH_STATS_EN
      chk("uf_cnt", 32'(underflow_cnt), 3);
`endif
      repeat (5) tick();
      chk("uf_sticky", 32'(underflow), 1);

      // New frame flushes the flag; then a second frame start lands mid-burst.
      base = log_addr.size();
      lcd_framesync = 1'b0;
      tick();
      lcd_framesync = 1'b1;
      tick();
      chk("flush_uf_clear", 32'(underflow), 0);
      chk("flush_count", 32'(fifo_count), 0);
`ifdef LCD_PIXEL_FETCH_STATS_EN
      chk("flush_uf_cnt", 32'(underflow_cnt), 0);
`endif
      for (int i = 0; i < 400 && fifo_count != 10'd20; i++) tick();
      chk("mid_burst_reached", 32'(fifo_count), 20);
      lcd_framesync = 1'b0;
      peak = 0;
      tick();
      lcd_framesync = 1'b1;
      for (int i = 0; i < 400 && log_addr.size() < base + 2; i++) tick();
      chk("midflush_bursts", 32'(log_addr.size()), 32'(base + 2));
      chk("midflush_first_addr", 32'(la(base)), 0);
      chk("midflush_peak", 32'(peak), 64);
      chk("midflush_count", 32'(fifo_count), 0);
      chk("midflush_next_addr", 32'(la(base + 1)), 0);
      chk("midflush_next_len", 32'(ll(base + 1)), 64);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/lcd_pixel_fetch.md
# lcd_pixel_fetch

Read-side pixel prefetch stage feeding `lcd_driver`. Pulls frame pixels from the frame-buffer memory controller in bursts, holds them in a show-ahead FIFO, and presents the head pixel on `lcd_data` whenever `lcd_driver` raises `lcd_request`. It restarts the frame address on each vertical sync so the display stays locked to the frame buffer.

## Interface

Parameters:

- `DEPTH`, 512: FIFO depth in 16-bit words; power of two, at least 2×`BURST_LEN`.
- `BURST_LEN`, 64: maximum words per memory read burst.
- `ADDR_W`, 24: memory word-address width.
- `FRAME_BASE`, 24'h000000: word address of the first pixel.
- `FRAME_WORDS`, 384000: pixels per frame (800×480).
- `UNDERFLOW_COLOR`, 16'h0000: pixel driven when the FIFO is empty.

Ports:

- `clk`, input, 1: system clock, same clock as `lcd_driver`.
- `rst_n`, input, 1: asynchronous active-low reset.
- `lcd_request`, input, 1: pixel request from `lcd_driver`; pops one word per cycle.
- `lcd_framesync`, input, 1: `lcd_vs` from `lcd_driver`; low during vertical sync.
- `lcd_data`, output, 16: RGB565 head pixel (show-ahead).
- `rd_req`, output, 1: burst read request, held until acknowledged.
- `rd_addr`, output, `ADDR_W`: burst start word address.
- `rd_len`, output, 8: burst length in words, 1..`BURST_LEN`.
- `rd_ack`, input, 1: one-cycle acceptance of `rd_req`.
- `rd_valid`, input, 1: read data strobe; gaps allowed.
- `rd_data`, input, 16: read data word.
- `fifo_count`, output, log2(`DEPTH`)+1: current FIFO occupancy.
- `underflow`, output, 1: sticky flag; set on a request made while the FIFO is empty.

## Operation

Frame start event:
- Defined as a falling edge of `lcd_framesync`, detected with a registered previous value.
- The event is latched as `flush_pend`.
- It is applied only in IDLE. At that point the block:
  - clears FIFO pointers and count,
  - sets the address to `FRAME_BASE`,
  - sets remaining words to `FRAME_WORDS`,
  - clears `underflow` and `flush_pend`.

State machine:
- IDLE → REQ when `flush_pend`=0, remaining>0, and `fifo_count` + `BURST_LEN` ≤ `DEPTH`.
  - On entry to REQ, register `rd_len` = min(`BURST_LEN`, remaining) and `rd_addr` = current address.
- REQ: `rd_req`=1 and may not be withdrawn. On `rd_ack`, go to DATA and set `rd_req`=0.
- DATA: each `rd_valid` writes `rd_data` to the FIFO and decrements the burst counter. After the last word:
  - address += `rd_len`,
  - remaining −= `rd_len`,
  - return to IDLE.
- A frame-start event during REQ or DATA never aborts the burst. The burst completes, its data is written, and the flush occurs in IDLE.

Pop rule:
- Pop when `lcd_request`=1 and the FIFO is not empty.
- Request while empty: no pop, `lcd_data`=`UNDERFLOW_COLOR`, and `underflow` is set.
- Push and pop in the same cycle leave `fifo_count` unchanged.

Overflow:
- Cannot occur, because bursts start only with `rd_len` words of free space.
- `rd_valid` outside DATA is ignored. This is a controller protocol error.

## Timing

Reset values:
- `rd_req`=0, `rd_addr`=`FRAME_BASE`, `rd_len`=0, `fifo_count`=0, `underflow`=0, state IDLE.
- Remaining = `FRAME_WORDS`, `flush_pend`=0.
- `lcd_data`=`UNDERFLOW_COLOR`.

Cycle behaviour:
- `lcd_data` is combinational from the FIFO head (asynchronous-read RAM). It is valid in the same cycle `lcd_request` is high, and advances to the next word one cycle after a pop.
- A word written on cycle N is visible on `lcd_data` from cycle N+1 when the FIFO was empty.
- IDLE → REQ takes 1 cycle after the condition holds. `rd_req` rises on the next edge.
- Flush completes 1 cycle after IDLE is reached with `flush_pend`=1.
- Pointers wrap modulo `DEPTH`. `fifo_count` ranges 0..`DEPTH`.
- Remaining and address arithmetic are unsigned with no wrap. Address stops at `FRAME_BASE`+`FRAME_WORDS`.
- Asserting `rst_n` low mid-burst returns the block to reset values immediately. The controller must also be reset.

## Configuration

- `LCD_PIXEL_FETCH_STATS_EN` defined: adds output `underflow_cnt`, 16 bits. It counts empty-FIFO requests in the current frame, saturates at 16'hFFFF, clears on flush, and resets to 0.
- Not defined: the port and counter are absent. `underflow` alone reports the condition.

## Test plan

- **Reset, then `lcd_framesync` 1→0 with an idle controller:** first burst `rd_addr`=0, `rd_len`=64, `rd_req` held until `rd_ack`.
- **Fill to steady state with no requests:** 8 bursts issued, addresses 0, 64, …, 448; `fifo_count`=512; no 9th `rd_req`.
- **`lcd_request` high for 800 cycles with a controller answering in 10 cycles:** `lcd_data` streams words 0..799 in order, `underflow`=0.
- **`FRAME_WORDS`=100 with `BURST_LEN`=64:** bursts have length 64 then 36; no further `rd_req` until the next frame start.
- **Frame-start edge during DATA after 20 of 64 words:** the remaining 44 words are accepted, then the flush occurs: `fifo_count`=0, next `rd_addr`=0.
- **`lcd_request` while empty for 3 cycles:** `lcd_data`=`UNDERFLOW_COLOR`, `underflow`=1 until the next flush; `underflow_cnt`=3 with `LCD_PIXEL_FETCH_STATS_EN` defined.
